// File: rtl/img_pkg.sv
// Shared types and defaults for the image frame sequencer: FSM state codes,
// operator select codes and default image geometry.
package img_pkg;

  localparam int IMG_N_DEF     = 450;
  localparam int IMG_M_DEF     = 450;
  localparam int IMG_TMO_DEF   = 15;
  localparam int OP_SEL_W      = 3;
  localparam int BYTES_PER_PIX = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_RES = 3'd2,
    ST_WRITE    = 3'd3,
    ST_DONE     = 3'd4
  } fs_state_e;

  typedef enum logic [OP_SEL_W-1:0] {
    OP_PASS = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AVG  = 3'd3,
    OP_MAX  = 3'd4,
    OP_MIN  = 3'd5,
    OP_GRAY = 3'd6,
    OP_INV  = 3'd7
  } op_sel_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/res_watchdog.sv
// Cycle counter bounding how long the sequencer waits for an operator result.
// expire is raised while the count sits at TMO-1; the count saturates there.
module res_watchdog
  import img_pkg::*;
#(
  parameter int TMO = IMG_TMO_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = cnt_w(TMO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Walks an N x M RGB frame: fetches three source bytes per pixel, waits for the
// operator result under a watchdog, then writes one destination pixel.
module frame_sequencer
  import img_pkg::*;
#(
  parameter int N      = IMG_N_DEF,
  parameter int M      = IMG_M_DEF,
  parameter int ADDR_W = 20,
  parameter int TMO    = IMG_TMO_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        op_sel,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic              src_valid,
  output logic              op_en,
  output logic [2:0]        op_select,
  input  logic              op_valid,
  output logic              dst_wr_en,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int NPIX  = N * M;
  localparam int PIX_W = cnt_w(NPIX);
  localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(NPIX - 1);
  localparam logic [1:0]       LAST_BYTE = 2'(BYTES_PER_PIX - 1);

  fs_state_e         state_q, state_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic [PIX_W-1:0]  pixel_cnt_q, pixel_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [2:0]        op_select_q, op_select_d;
  logic              error_q, error_d;
  logic              tmo_clear, tmo_en, tmo_expire;

  res_watchdog #(.TMO(TMO)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clear),
    .enable (tmo_en),
    .expire (tmo_expire)
  );

  always_comb begin
    state_d     = state_q;
    src_addr_d  = src_addr_q;
    pixel_cnt_d = pixel_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    op_select_d = op_select_q;
    error_d     = error_q;
    tmo_clear   = 1'b0;
    tmo_en      = 1'b0;

    // abort outranks every in-frame event; error is left as it was
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d     = ST_FETCH;
            op_select_d = op_sel;
            pixel_cnt_d = '0;
            src_addr_d  = '0;
            byte_cnt_d  = '0;
            error_d     = 1'b0;
          end
        end
        ST_FETCH: begin
          if (src_valid) begin
            src_addr_d = src_addr_q + ADDR_W'(1);
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_d = '0;
              tmo_clear  = 1'b1;
              state_d    = ST_WAIT_RES;
            end else begin
              byte_cnt_d = byte_cnt_q + 2'd1;
            end
          end
        end
        ST_WAIT_RES: begin
          if (op_valid) begin
            state_d = ST_WRITE;
          end else if (tmo_expire) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tmo_en = 1'b1;
          end
        end
        ST_WRITE: begin
          // last pixel does not advance the counter, so it never wraps
          if (pixel_cnt_q == LAST_PIX) begin
            state_d = ST_DONE;
          end else begin
            pixel_cnt_d = pixel_cnt_q + PIX_W'(1);
            state_d     = ST_FETCH;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      src_addr_q  <= '0;
      pixel_cnt_q <= '0;
      byte_cnt_q  <= '0;
      op_select_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_addr_q  <= src_addr_d;
      pixel_cnt_q <= pixel_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      op_select_q <= op_select_d;
      error_q     <= error_d;
    end
  end

  assign src_rd_en = (state_q == ST_FETCH);
  assign op_en     = (state_q == ST_FETCH) || (state_q == ST_WAIT_RES) ||
                     (state_q == ST_WRITE);
  // an abort landing on the WRITE cycle must not reach destination memory
  assign dst_wr_en = (state_q == ST_WRITE) && !abort;
  assign dst_addr  = ADDR_W'(pixel_cnt_q);
  assign src_addr  = src_addr_q;
  assign op_select = op_select_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign error     = error_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer on a 2x2 frame with a 4-cycle result timeout.
module tb_frame_sequencer;

  localparam int N = 2, M = 2, ADDR_W = 8, TMO = 4;

  logic              clk = 1'b0;
  logic              rst, start, abort, src_valid, op_valid;
  logic [2:0]        op_sel;
  logic              src_rd_en, op_en, dst_wr_en, busy, done, error;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic [2:0]        op_select;

  frame_sequencer #(.N(N), .M(M), .ADDR_W(ADDR_W), .TMO(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .op_sel    (op_sel),
    .src_rd_en (src_rd_en),
    .src_addr  (src_addr),
    .src_valid (src_valid),
    .op_en     (op_en),
    .op_select (op_select),
    .op_valid  (op_valid),
    .dst_wr_en (dst_wr_en),
    .dst_addr  (dst_addr),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  int done_total = 0;
  logic [ADDR_W-1:0] wr_log[$];

  always @(posedge clk) begin
    if (dst_wr_en) wr_log.push_back(dst_addr);
    if (done) done_total <= done_total + 1;
  end

  // Packed observation: {rd, op_en, wr, busy, done, err, sel[2:0], src[7:0], dst[7:0]}
  function automatic logic [31:0] mk(int rd, int op, int wr, int bsy, int dn,
                                     int er, int sel, int src, int dst);
    return {7'd0, 1'(rd), 1'(op), 1'(wr), 1'(bsy), 1'(dn), 1'(er),
            3'(sel), 8'(src), 8'(dst)};
  endfunction

  function automatic logic [31:0] obs();
    return mk(int'(src_rd_en), int'(op_en), int'(dst_wr_en), int'(busy),
              int'(done), int'(error), int'(op_select), int'(src_addr),
              dst_wr_en ? int'(dst_addr) : 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  typedef struct {
    logic       start;
    logic [2:0] op_sel;
    logic       src_valid;
    logic       op_valid;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[23];

  initial begin
    int wb, db, p, ph;
    rst = 1'b1; start = 1'b0; abort = 1'b0; src_valid = 1'b0; op_valid = 1'b0;
    op_sel = 3'd0;

    // Full-speed frame timeline: pixel p spans cycles 5p+1..5p+5, done at 21
    for (int i = 0; i < 23; i++) begin
      vt[i].start     = (i == 0);
      vt[i].op_sel    = 3'd3;
      vt[i].src_valid = 1'b1;
      vt[i].op_valid  = 1'b1;
      if (i == 0) begin
        vt[i].exp = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      end else if (i <= 20) begin
        p  = (i - 1) / 5;
        ph = (i - 1) % 5;
        vt[i].exp = mk((ph < 3) ? 1 : 0, 1, (ph == 4) ? 1 : 0, 1, 0, 0, 3,
                       (ph < 3) ? 3 * p + ph : 3 * p + 3, (ph == 4) ? p : 0);
      end else if (i == 21) begin
        vt[i].exp = mk(0, 0, 0, 1, 1, 0, 3, 12, 0);
      end else begin
        vt[i].exp = mk(0, 0, 0, 0, 0, 0, 3, 12, 0);
      end
    end

    repeat (3) tick();
    check("reset state", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    tick();

    // Nominal frame
    for (int i = 0; i < 23; i++) begin
      check($sformatf("frame vec %0d", i), obs(), vt[i].exp);
      start = vt[i].start; op_sel = vt[i].op_sel;
      src_valid = vt[i].src_valid; op_valid = vt[i].op_valid;
      tick();
    end
    check("frame write count", wr_log.size(), 4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++)
      check($sformatf("frame write addr %0d", i), 32'(wr_log[i]), i);
    check("frame done count", done_total, 1);

    // Source stall of two cycles after the first byte
    wb = wr_log.size(); db = done_total;
    start = 1'b1; op_sel = 3'd4; src_valid = 1'b1; op_valid = 1'b1; cyc = 0;
    tick(); start = 1'b0;
    tick(); check("stall c2 src_addr", 32'(src_addr), 1); src_valid = 1'b0;
    tick(); check("stall c3 src_addr", 32'(src_addr), 1);
    tick(); check("stall c4 src_addr", 32'(src_addr), 1); src_valid = 1'b1;
    while (!done && cyc < 60) tick();
    check("stall done cycle", cyc, 23);
    tick();
    check("stall write count", wr_log.size() - wb, 4);
    check("stall done count", done_total - db, 1);

    // Operator never answers: timeout after four WAIT_RES cycles
    wb = wr_log.size(); db = done_total;
    start = 1'b1; op_sel = 3'd6; src_valid = 1'b1; op_valid = 1'b0; cyc = 0;
    tick(); start = 1'b0;
    repeat (6) tick();
    check("tmo last wait cycle", obs(), mk(0, 1, 0, 1, 0, 0, 6, 3, 0));
    tick();
    check("tmo idle with error", obs(), mk(0, 0, 0, 0, 0, 1, 6, 3, 0));
    tick();
    check("tmo error sticky", 32'(error), 1);
    check("tmo write count", wr_log.size() - wb, 0);
    check("tmo done count", done_total - db, 0);

    // Abort on the second WRITE cycle
    wb = wr_log.size(); db = done_total;
    start = 1'b1; op_sel = 3'd2; src_valid = 1'b1; op_valid = 1'b1; cyc = 0;
    tick(); start = 1'b0;
    check("start clears error", obs(), mk(1, 1, 0, 1, 0, 0, 2, 0, 0));
    repeat (9) tick();
    check("second write cycle", obs(), mk(0, 1, 1, 1, 0, 0, 2, 6, 1));
    abort = 1'b1;
    tick(); abort = 1'b0;
    check("abort to idle", obs(), mk(0, 0, 0, 0, 0, 0, 2, 6, 0));
    repeat (3) tick();
    check("abort write count", wr_log.size() - wb, 1);
    if (wr_log.size() > wb) check("abort write addr", 32'(wr_log[wb]), 0);
    check("abort done count", done_total - db, 0);

    // Restart after abort, start while busy, reset mid-FETCH
    start = 1'b1; op_sel = 3'd5; cyc = 0;
    tick(); start = 1'b0;
    check("restart src_addr 0", obs(), mk(1, 1, 0, 1, 0, 0, 5, 0, 0));
    tick(); start = 1'b1; op_sel = 3'd1;
    tick(); start = 1'b0;
    check("busy start ignored", obs(), mk(1, 1, 0, 1, 0, 0, 5, 2, 0));
    rst = 1'b1;
    tick();
    check("mid-fetch reset", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    tick();
    check("idle after reset", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter N, default 450: image width in pixels.
REQ-002 Parameter M, default 450: image height in pixels.
REQ-003 Parameter ADDR_W, default 20: source byte-address width; SHALL satisfy 2^ADDR_W >= 3*N*M.
REQ-004 Parameter TMO, default 15: maximum cycles allowed for an operator result.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 Ports, in order:
- clk in 1: clock, rising edge.
- rst in 1: synchronous active-high reset.
- start in 1: single-cycle frame start request.
- abort in 1: terminate the frame immediately.
- op_sel in 3: arithmetic select, latched at accepted start.
- src_rd_en out 1: read request to source memory.
- src_addr out ADDR_W: source byte address.
- src_valid in 1: source byte present this cycle.
- op_en out 1: enable to RGB operator.
- op_select out 3: latched arithmetic select.
- op_valid in 1: operator result valid.
- dst_wr_en out 1: write strobe to destination memory.
- dst_addr out ADDR_W: destination pixel address.
- busy out 1: frame in progress.
- done out 1: single-cycle frame-complete pulse.
- error out 1: sticky timeout flag.

Function
REQ-007 States SHALL be IDLE, FETCH, WAIT_RES, WRITE and DONE.
REQ-008 IDLE: start=1 SHALL latch op_sel, clear pixel_cnt, src_addr and error, and enter FETCH; start while not IDLE SHALL be ignored.
REQ-009 FETCH: src_rd_en=1; each cycle with src_valid=1 SHALL increment src_addr and byte_cnt (0..2); after the third accepted byte, the block SHALL enter WAIT_RES and clear the timeout counter.
REQ-010 FETCH with src_valid=0 SHALL hold src_addr and byte_cnt (stall, no limit).
REQ-011 op_en SHALL be 1 in FETCH, WAIT_RES and WRITE, and 0 otherwise; op_select SHALL be held constant for the whole frame.
REQ-012 WAIT_RES: op_valid=1 SHALL enter WRITE; otherwise tmo_cnt increments, and at tmo_cnt==TMO-1 the block SHALL set error=1 and return to IDLE without done.
REQ-013 op_valid outside WAIT_RES SHALL be ignored.
REQ-014 WRITE: dst_wr_en=1 for exactly one cycle with dst_addr=pixel_cnt; then pixel_cnt increments; pixel_cnt==N*M-1 SHALL enter DONE, otherwise FETCH.
REQ-015 DONE: done=1 for one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-016 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done, no write and error unchanged; abort takes priority over all other events.
REQ-017 Minimum latency per pixel is 5 cycles (3 FETCH, 1 WAIT_RES, 1 WRITE); frame latency is >= 5*N*M+1 cycles.
REQ-018 pixel_cnt SHALL be ceil(log2(N*M)) bits; counters SHALL never wrap within a frame.

Reset
REQ-019 rst=1 SHALL force IDLE, with src_addr=0, dst_addr=0, pixel_cnt=0, byte_cnt=0, tmo_cnt=0, op_select=0, src_rd_en=0, op_en=0, dst_wr_en=0, busy=0, done=0 and error=0; mid-frame reset behaves identically.

Structure
REQ-020 State encodings, the default N/M/TMO values and the op_sel codes SHALL reside in a shared package img_pkg.
REQ-021 The timeout counter SHALL be a sub-module, res_watchdog (clear, enable, expire output); all other logic is flat.

Verification (N=2, M=2, TMO=4)
REQ-022 start, op_sel=3, src_valid=1 always, op_valid one cycle into WAIT_RES -> 4 dst writes at addr 0..3; src_addr ends at 12; done pulses once at cycle 21; op_select=3 throughout.
REQ-023 src_valid low for 2 cycles after the first byte -> src_addr holds; the frame completes 2 cycles later than REQ-022.
REQ-024 op_valid never asserted -> after 4 WAIT_RES cycles: error=1, state IDLE, busy=0, no dst_wr_en, no done.
REQ-025 abort during the second WRITE -> IDLE next cycle; only 1 write recorded, no done; a new start then restarts at src_addr=0.
REQ-026 start pulsed while busy, and rst asserted mid-FETCH -> start is ignored (op_select unchanged); reset clears all outputs per REQ-019 on the next edge.
